qrs_window_max_thr: RTL and testbench
=====================================

// Module: qrs_window_max_thr
// PURPOSE
//   Parametrised windowed-maximum and threshold tracker for the QRS detector.
//   Scans the detail-coefficient stream (cd3) in fixed windows of WIN accepted samples.
//   At each window end it reports the window peak, the peak's index and a scaled detection threshold.
//   It feeds the QRS peak finder, and clears its running max every window.
// PARAMETERS
//   DW        16   sample / maxval / thr width
//   WIN       800  accepted samples per window (>=1)
//   IDXW      10   index width; must satisfy 2**IDXW >= WIN
//   THR_NUM   5    threshold numerator (unsigned, 4 bits max)
//   THR_SHIFT 3    threshold = maxval*THR_NUM >> THR_SHIFT (default 0.625)
//   SIGNED    0    0: unsigned compare/arith; 1: two's-complement
//   AVG_SHIFT 2    averaging weight 2^-AVG_SHIFT (used only with QRS_THR_AVG_EN)
// PORTS
//   clk3        in   1     clock, rising edge
//   rst_n       in   1     asynchronous active-low reset
//   din_valid   in   1     cd3 accepted on this edge when high
//   cd3         in   DW    input sample
//   win_restart in   1     sync clear of the current window (cnt and running max)
//   enable      out  1     sticky; high once first window completes
//   win_done    out  1     1-cycle pulse: new maxval/max_idx/thr valid
//   maxval      out  DW    peak of the last completed window
//   max_idx     out  IDXW  in-window index (0..WIN-1) of that peak
//   thr         out  DW    detection threshold
// BEHAVIOUR
//   - Reset (async, rst_n=0): cnt, run_max, run_idx, all outputs = 0; enable=0.
//   - Accepted sample (din_valid=1):
//     - cnt==0: run_max<=cd3 and run_idx<=0 unconditionally, so no stale max carries over.
//     - cnt>0: replace only if cd3 > run_max (strict), so ties keep the earliest index.
//   - cnt increments per accepted sample; wraps WIN-1 -> 0. din_valid=0: all state held.
//   - Completion: on the edge accepting the sample with cnt==WIN-1:
//     - maxval/max_idx <= final max (including that sample); thr updated on the same edge.
//     - win_done=1 for exactly the next cycle; enable<=1 and stays set until reset.
//     - Latency: 1 cycle from last sample to valid outputs.
//   - Between completions, maxval/max_idx/thr hold their values.
//   - Scaling: scaled = (maxval_new*THR_NUM) >> THR_SHIFT, computed at DW+4 bits.
//     - Saturates to the DW range: unsigned max 2^DW-1; signed max/min.
//     - SIGNED=1 uses arithmetic shift and $signed compares.
//   - win_restart=1: cnt<=0 and the running max is invalidated; outputs are untouched.
//     - With din_valid=1 on the same edge, that sample becomes index 0 of the new window.
//     - Restart beats completion: no win_done, and maxval is not updated.
//   - WIN=1: every accepted sample completes a window (win_done may stay high back-to-back).
//   - Reset mid-window discards the partial window; the next accepted sample is index 0.
// CONFIGURATION
//   QRS_THR_AVG_EN defined: thr is an exponential average of the scaled window peaks.
//     - First completion: avg<=scaled.
//     - Later completions: avg<=avg+((scaled-avg)>>>AVG_SHIFT), signed DW+1 difference.
//     - thr=avg.
//   QRS_THR_AVG_EN undefined: thr=scaled of the current window only; no avg register.
// TESTING (WIN=8, IDXW=3, default THR, SIGNED=0 unless noted)
//   1. Assert rst_n=0 mid-stream -> all outputs 0 and enable=0 immediately (async).
//      After release, the next sample is index 0.
//   2. Samples 1..8 with continuous valid -> win_done one cycle after the 8th sample.
//      maxval=8, max_idx=7, thr=5, enable=1.
//   3. Next window all 3s -> maxval=3 (not 8), max_idx=0, thr=1, enable still 1.
//   4. Window 2,9,9,1,0,0,0,0 sent with valid every other cycle -> win_done after 16 cycles.
//      maxval=9, max_idx=1.
//   5. win_restart with the 6th sample (value 4, valid) -> no win_done.
//      Window completes 7 samples later; idx counted from that 4.
//      SIGNED=1 window of -5s -> maxval=0xFFFB, thr=-4 (0xFFFC).
//   6. QRS_THR_AVG_EN defined, window peaks 8 then 16 -> thr=5, then 5+((10-5)>>2)=6.

Source files
------------

// File: rtl/qrs_window_max_thr_if.sv
// Sample/result bundle for the QRS windowed-max threshold tracker.
// The master drives cd3 samples and restarts; the slave returns window results.
interface qrs_window_max_thr_if #(
    parameter int DW   = 16,
    parameter int IDXW = 10
);
    logic            din_valid;
    logic [DW-1:0]   cd3;
    logic            win_restart;
    logic            enable;
    logic            win_done;
    logic [DW-1:0]   maxval;
    logic [IDXW-1:0] max_idx;
    logic [DW-1:0]   thr;

    modport master (
        output din_valid, cd3, win_restart,
        input  enable, win_done, maxval, max_idx, thr
    );

    modport slave (
        input  din_valid, cd3, win_restart,
        output enable, win_done, maxval, max_idx, thr
    );
endinterface

// File: rtl/qrs_window_max_thr.sv
// Windowed peak / threshold tracker over the cd3 stream, one result per WIN samples.
// Optional macro QRS_THR_AVG_EN: thr becomes an exponential average of window thresholds.
module qrs_window_max_thr #(
    parameter int DW        = 16,
    parameter int WIN       = 800,
    parameter int IDXW      = 10,
    parameter int THR_NUM   = 5,
    parameter int THR_SHIFT = 3,
    parameter int SIGNED    = 0,
    parameter int AVG_SHIFT = 2
) (
    input  logic                 clk3,
    input  logic                 rst_n,
    qrs_window_max_thr_if.slave  bus
);
    // One guard bit above DW+4 lets unsigned and signed modes share signed math.
    localparam int PW = DW + 5;
    localparam logic [IDXW-1:0]      LAST   = IDXW'(WIN - 1);
    localparam logic signed [PW-1:0] NUM_W  = PW'(THR_NUM);
    localparam logic signed [PW-1:0] SAT_HI = (SIGNED != 0) ?
        {{6{1'b0}}, {(DW-1){1'b1}}} : {{5{1'b0}}, {DW{1'b1}}};
    localparam logic signed [PW-1:0] SAT_LO = (SIGNED != 0) ?
        {{6{1'b1}}, {(DW-1){1'b0}}} : '0;

    logic [IDXW-1:0] cnt, run_idx;
    logic [DW-1:0]   run_max;
    logic            enable_q, done_q;
    logic [DW-1:0]   maxval_q, thr_q;
    logic [IDXW-1:0] idx_q;

    logic            first, take, complete;
    logic [DW-1:0]   new_max;
    logic [IDXW-1:0] new_idx, cnt_nxt;
    logic signed [PW-1:0] ext, prod, shf;
    logic [DW-1:0]   scaled, thr_nxt;

    function automatic logic gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        else             return a > b;
    endfunction

    always_comb begin
        // A restart or a window start forces the sample in, so no stale max survives.
        first    = (cnt == '0) || bus.win_restart;
        take     = first || gt(bus.cd3, run_max);
        new_max  = take ? bus.cd3 : run_max;
        new_idx  = bus.win_restart ? '0 : (take ? cnt : run_idx);
        complete = bus.din_valid && !bus.win_restart && (cnt == LAST);

        cnt_nxt = cnt;
        if (bus.win_restart)
            cnt_nxt = (bus.din_valid && WIN > 1) ? IDXW'(1) : '0;
        else if (bus.din_valid)
            cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    always_comb begin
        ext  = (SIGNED != 0) ? {{5{new_max[DW-1]}}, new_max} : {5'b0, new_max};
        prod = ext * NUM_W;
        shf  = prod >>> THR_SHIFT;
        if (shf > SAT_HI)      scaled = SAT_HI[DW-1:0];
        else if (shf < SAT_LO) scaled = SAT_LO[DW-1:0];
        else                   scaled = shf[DW-1:0];
    end

`ifdef QRS_THR_AVG_EN
    // thr_q doubles as the average register; enable_q low marks the first window.
    logic signed [DW:0] avg_x, scl_x, diff, step, sum;
    always_comb begin
        avg_x   = (SIGNED != 0) ? {thr_q[DW-1], thr_q} : {1'b0, thr_q};
        scl_x   = (SIGNED != 0) ? {scaled[DW-1], scaled} : {1'b0, scaled};
        diff    = scl_x - avg_x;
        step    = diff >>> AVG_SHIFT;
        sum     = avg_x + step;
        thr_nxt = enable_q ? sum[DW-1:0] : scaled;
    end
`else
    always_comb thr_nxt = scaled;
`endif

    always_ff @(posedge clk3 or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            run_max  <= '0;
            run_idx  <= '0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            maxval_q <= '0;
            idx_q    <= '0;
            thr_q    <= '0;
        end else begin
            cnt    <= cnt_nxt;
            done_q <= complete;
            if (bus.din_valid) begin
                run_max <= new_max;
                run_idx <= new_idx;
            end
            if (complete) begin
                maxval_q <= new_max;
                idx_q    <= new_idx;
                thr_q    <= thr_nxt;
                enable_q <= 1'b1;
            end
        end
    end

    assign bus.enable   = enable_q;
    assign bus.win_done = done_q;
    assign bus.maxval   = maxval_q;
    assign bus.max_idx  = idx_q;
    assign bus.thr      = thr_q;
endmodule

// File: tb/tb_qrs_window_max_thr.sv
// Randomized + directed bench for qrs_window_max_thr (WIN=8) against a queue-based model.
// Three instances: unsigned default, signed default, signed 15/2 to exercise saturation.
module tb_qrs_window_max_thr;
    localparam int WIN = 8;

    logic clk3  = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk3 = ~clk3;

    qrs_window_max_thr_if #(.DW(16), .IDXW(3)) bu ();
    qrs_window_max_thr_if #(.DW(16), .IDXW(3)) bs ();
    qrs_window_max_thr_if #(.DW(16), .IDXW(3)) bx ();

    qrs_window_max_thr #(.DW(16), .WIN(WIN), .IDXW(3), .THR_NUM(5), .THR_SHIFT(3),
        .SIGNED(0), .AVG_SHIFT(2)) dut_u (.clk3(clk3), .rst_n(rst_n), .bus(bu));
    qrs_window_max_thr #(.DW(16), .WIN(WIN), .IDXW(3), .THR_NUM(5), .THR_SHIFT(3),
        .SIGNED(1), .AVG_SHIFT(2)) dut_s (.clk3(clk3), .rst_n(rst_n), .bus(bs));
    qrs_window_max_thr #(.DW(16), .WIN(WIN), .IDXW(3), .THR_NUM(15), .THR_SHIFT(1),
        .SIGNED(1), .AVG_SHIFT(2)) dut_x (.clk3(clk3), .rst_n(rst_n), .bus(bx));

    int n_cmp = 0;
    int n_err = 0;

    int c_sg  [3] = '{0, 1, 1};
    int c_num [3] = '{5, 5, 15};
    int c_sh  [3] = '{3, 3, 1};

    logic [15:0] q[$];
    bit          e_done, e_en;
    logic [15:0] e_max [3];
    logic [15:0] e_thr [3];
    logic [2:0]  e_idx [3];
    int          avg   [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int val(input logic [15:0] r, input int sg);
        if (sg != 0) return int'($signed(r));
        return int'(r);
    endfunction

    function automatic int scale(input int v, input int sg, input int num, input int sh);
        longint p;
        p = longint'(v) * num;
        p = p >>> sh;
        if (sg != 0) begin
            if (p > 32767)  p = 32767;
            if (p < -32768) p = -32768;
        end else if (p > 65535) p = 65535;
        return int'(p);
    endfunction

    task automatic model_reset();
        q.delete();
        e_done = 0;
        e_en   = 0;
        for (int k = 0; k < 3; k++) begin
            e_max[k] = '0; e_thr[k] = '0; e_idx[k] = '0; avg[k] = 0;
        end
    endtask

    task automatic model_edge(input bit v, input logic [15:0] d, input bit r);
        int best, sc;
        e_done = 0;
        if (r) q.delete();
        if (v) q.push_back(d);
        if (q.size() == WIN) begin
            if (!r) begin
                for (int k = 0; k < 3; k++) begin
                    best = 0;
                    for (int i = 1; i < WIN; i++)
                        if (val(q[i], c_sg[k]) > val(q[best], c_sg[k])) best = i;
                    sc = scale(val(q[best], c_sg[k]), c_sg[k], c_num[k], c_sh[k]);
`ifdef QRS_THR_AVG_EN
                    if (!e_en) avg[k] = sc;
                    else       avg[k] = avg[k] + ((sc - avg[k]) >>> 2);
`else
                    avg[k] = sc;
`endif
                    e_max[k] = q[best];
                    e_idx[k] = 3'(best);
                    e_thr[k] = 16'(avg[k]);
                end
                e_done = 1;
                e_en   = 1;
            end
            q.delete();
        end
    endtask

    task automatic check_one(input string n, input logic done, input logic en,
                             input logic [15:0] mx, input logic [2:0] ix,
                             input logic [15:0] th, input int k);
        chk({n, "_win_done"}, done, e_done);
        chk({n, "_enable"},   en,   e_en);
        chk({n, "_maxval"},   mx,   e_max[k]);
        chk({n, "_max_idx"},  ix,   e_idx[k]);
        chk({n, "_thr"},      th,   e_thr[k]);
    endtask

    task automatic check_all();
        check_one("u", bu.win_done, bu.enable, bu.maxval, bu.max_idx, bu.thr, 0);
        check_one("s", bs.win_done, bs.enable, bs.maxval, bs.max_idx, bs.thr, 1);
        check_one("x", bx.win_done, bx.enable, bx.maxval, bx.max_idx, bx.thr, 2);
    endtask

    task automatic drive(input bit v, input logic [15:0] d, input bit r);
        bu.din_valid = v; bu.cd3 = d; bu.win_restart = r;
        bs.din_valid = v; bs.cd3 = d; bs.win_restart = r;
        bx.din_valid = v; bx.cd3 = d; bx.win_restart = r;
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic cyc(input bit v, input logic [15:0] d, input bit r);
        drive(v, d, r);
        @(posedge clk3);
        model_edge(v, d, r);
        @(negedge clk3);
        check_all();
    endtask

    logic [15:0] pat4 [8] = '{16'd2, 16'd9, 16'd9, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
    logic [15:0] tail5[7] = '{16'd1, 16'd2, 16'd1, 16'd5, 16'd1, 16'd1, 16'd1};
    logic [15:0] ext_v[4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};

    initial begin
        logic [15:0] d;
        drive(0, '0, 0);
        model_reset();
        #1;
        check_all();
        @(negedge clk3);
        rst_n = 1'b1;
        @(negedge clk3);

        // Ramp 1..8: peak at the last index.
        for (int i = 1; i <= 8; i++) cyc(1, 16'(i), 0);
        chk("t2_max", bu.maxval, 16'd8);
        chk("t2_idx", bu.max_idx, 32'd7);
        chk("t2_thr", bu.thr, 16'd5);
        chk("t2_done", bu.win_done, 1'b1);
        cyc(0, '0, 0);
        chk("t2_done_pulse", bu.win_done, 1'b0);

        // Flat window: ties keep index 0, old peak must not carry over.
        for (int i = 0; i < 8; i++) cyc(1, 16'd3, 0);
        chk("t3_max", bu.maxval, 16'd3);
        chk("t3_idx", bu.max_idx, 32'd0);

        // Sparse valid.
        for (int i = 0; i < 8; i++) begin
            cyc(1, pat4[i], 0);
            if (i != 7) cyc(0, 16'hAAAA, 0);
        end
        chk("t4_max", bu.maxval, 16'd9);
        chk("t4_idx", bu.max_idx, 32'd1);

        // Restart with the 6th sample.
        for (int i = 0; i < 5; i++) cyc(1, 16'd7, 0);
        cyc(1, 16'd4, 1);
        for (int i = 0; i < 7; i++) cyc(1, tail5[i], 0);
        chk("t5_max", bu.maxval, 16'd5);
        chk("t5_idx", bu.max_idx, 32'd4);

        // Restart on what would have been the closing sample, then a clean window.
        for (int i = 0; i < 7; i++) cyc(1, 16'd20, 0);
        cyc(1, 16'd1, 1);
        cyc(0, '0, 1);
        for (int i = 0; i < 8; i++) cyc(1, 16'hFFFB, 0);
        chk("t5_sgn_max", bs.maxval, 16'hFFFB);

        // Saturation extremes on the 15/2 instance.
        for (int i = 0; i < 8; i++) cyc(1, 16'h8000, 0);
        for (int i = 0; i < 8; i++) cyc(1, (i == 3) ? 16'h7FFF : 16'h0010, 0);

        // Asynchronous reset in the middle of a window.
        for (int i = 0; i < 3; i++) cyc(1, 16'd50, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("t1_async_en", bu.enable, 1'b0);
        @(negedge clk3);
        check_all();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cyc(1, 16'(8 - i), 0);
        chk("t1_idx0", bu.max_idx, 32'd0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) d = ext_v[$urandom_range(0, 3)];
            else                           d = 16'($urandom);
            cyc($urandom_range(0, 9) < 7, d, $urandom_range(0, 31) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
